// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-core memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam int MAX_NCORES = 8;

    // Width of a core index; a single core still gets one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Picks one pending core as the winner; round-robin when MEM_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with the lowest index first.
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int IW     = idx_width(NCORES)
)
(
    input  logic [NCORES-1:0] pending,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0]     ptr,
`endif
    output logic [NCORES-1:0] onehot,
    output logic [IW-1:0]     index
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Each pending core is ranked by its distance past the last winner; nearest wins.
    always_comb begin
        int best;
        int dist;
        onehot = '0;
        index  = '0;
        best   = NCORES;
        dist   = 0;
        for (int i = 0; i < NCORES; i++) begin
            dist = (i + NCORES - 1 - int'(ptr)) % NCORES;
            if (pending[i] && dist < best) begin
                best      = dist;
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IW'(i);
            end
        end
    end
`else
    always_comb begin
        onehot = '0;
        index  = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// N-core arbiter for one shared single-port RAM, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin fairness instead of fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCORES  = 2,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RAM_LAT = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    rden,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES*AW-1:0] Address,
    input  logic [NCORES*DW-1:0] Din,
    output logic [NCORES-1:0]    acq,
    output logic [NCORES*DW-1:0] Dq,
    output logic [NCORES-1:0]    grant,
    output logic                 busy,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren,
    input  logic [DW-1:0]        RAMq
);

    localparam int         IW       = idx_width(NCORES);
    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    state_t            state;
    logic [IW-1:0]     win_idx;
    logic [1:0]        wait_cnt;
    logic [NCORES-1:0] pending;
    logic [NCORES-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;

    assign pending = rden | wren;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;

    mem_arb_picker #(.NCORES(NCORES), .IW(IW)) u_picker (
        .pending (pending),
        .ptr     (ptr),
        .onehot  (pick_oh),
        .index   (pick_idx)
    );

    // Starting at NCORES-1 makes core 0 the first choice after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= IW'(NCORES - 1);
        else if (state == DONE)
            ptr <= win_idx;
    end
`else
    mem_arb_picker #(.NCORES(NCORES), .IW(IW)) u_picker (
        .pending (pending),
        .onehot  (pick_oh),
        .index   (pick_idx)
    );
`endif

    // RAMwren doubles as the latched op type while in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            win_idx    <= '0;
            wait_cnt   <= '0;
            acq        <= '0;
            Dq         <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        win_idx <= pick_idx;
                        grant   <= pick_oh;
                        busy    <= 1'b1;
                        RAMwren <= |(wren & pick_oh);
                        for (int c = 0; c < NCORES; c++) begin
                            if (pick_oh[c]) begin
                                RAMAddress <= Address[c*AW +: AW];
                                RAMDin     <= Din[c*DW +: DW];
                            end
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    RAMwren <= 1'b0;
                    if (RAMwren) begin
                        acq   <= grant;
                        state <= DONE;
                    end else begin
                        wait_cnt <= LAT_LAST;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        for (int c = 0; c < NCORES; c++) begin
                            if (win_idx == IW'(c))
                                Dq[c*DW +: DW] <= RAMq;
                        end
                        acq   <= grant;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    acq   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
